// File: rtl/dr_rx_decoder.sv
// dr_rx_decoder: four-phase dual-rail receiver with synchronizer, spacer/codeword FSM and ready/valid output.
// Optional DR_RX_DECODER_ALT_SPACER_EN: expected spacer polarity alternates after every capture.
module dr_rx_decoder #(
    parameter int WIDTH       = 4,
    parameter bit SPACER      = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D_1,
    input  logic [WIDTH-1:0] D_0,
    output logic             ACK,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    input  logic             Q_READY,
    output logic             ERR
);
    typedef enum logic {WAIT_CW, WAIT_SP} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] sync_1 [SYNC_STAGES];
    logic [WIDTH-1:0] sync_0 [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] sync_v;
    logic [WIDTH-1:0] r1, r0, valid_bits, spacer_bits, illegal_bits, q_n;
    logic primed, all_valid, all_spacer, any_illegal, capture, advance;
    logic ack_n, q_valid_n, err_n, s_exp;
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_1[i] <= {WIDTH{SPACER}};
                sync_0[i] <= {WIDTH{SPACER}};
                sync_v[i] <= 1'b0;
            end
        end else begin
            sync_1[0] <= D_1;
            sync_0[0] <= D_0;
            sync_v[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_1[i] <= sync_1[i-1];
                sync_0[i] <= sync_0[i-1];
                sync_v[i] <= sync_v[i-1];
            end
        end
    end
    // The synchronizer's reset contents are not real samples, so the FSM ignores them
    assign primed = sync_v[SYNC_STAGES-1];
    assign r1 = sync_1[SYNC_STAGES-1];
    assign r0 = sync_0[SYNC_STAGES-1];
    assign valid_bits   = r1 ^ r0;
    assign spacer_bits  = ~(r1 ^ r0) & ~(r1 ^ {WIDTH{s_exp}});
    assign illegal_bits = ~(r1 ^ r0) & (r1 ^ {WIDTH{s_exp}});
    assign all_valid   = &valid_bits;
    assign all_spacer  = &spacer_bits;
    assign any_illegal = |illegal_bits;
    assign capture = primed && state == WAIT_CW && all_valid && (!Q_VALID || Q_READY);
    assign advance = primed && state == WAIT_SP && all_spacer;
`ifdef DR_RX_DECODER_ALT_SPACER_EN
    always_ff @(posedge CLK) begin
        if (RST) s_exp <= SPACER;
        else     s_exp <= s_exp ^ capture;
    end
`else
    assign s_exp = SPACER;
`endif
    always_comb begin
        state_n   = capture ? WAIT_SP : advance ? WAIT_CW : state;
        ack_n     = capture ? 1'b1 : advance ? 1'b0 : ACK;
        q_n       = capture ? r1 : Q;
        q_valid_n = capture | (Q_VALID & ~Q_READY);
        err_n     = ERR | any_illegal;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= WAIT_SP;
            ACK     <= 1'b0;
            Q       <= '0;
            Q_VALID <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            state   <= state_n;
            ACK     <= ack_n;
            Q       <= q_n;
            Q_VALID <= q_valid_n;
            ERR     <= err_n;
        end
    end
endmodule

// File: tb/tb_dr_rx_decoder.sv
// tb_dr_rx_decoder: vector table, directed handshake sequences and random traffic against a count-based model.
module tb_dr_rx_decoder;
    localparam int W  = 4;
    localparam int SS = 2;
    localparam bit SP = 1'b0;
    logic CLK = 1'b0, RST = 1'b1, Q_READY = 1'b0;
    logic [W-1:0] D_1 = '0, D_0 = '0, Q;
    logic ACK, Q_VALID, ERR;
    int tests = 0, fails = 0;
    dr_rx_decoder #(.WIDTH(W), .SPACER(SP), .SYNC_STAGES(SS)) dut (
        .CLK(CLK), .RST(RST), .D_1(D_1), .D_0(D_0), .ACK(ACK),
        .Q(Q), .Q_VALID(Q_VALID), .Q_READY(Q_READY), .ERR(ERR)
    );
    always #5 CLK = ~CLK;

    // Reference: a word is seen SS edges after it is driven; a capture needs
    // every bit valid, a release needs every bit equal to the expected spacer.
    logic [W-1:0] h1 [$], h0 [$], ms1, ms0, m_q;
    logic m_ack, m_qv, m_err, m_want_cw, m_sexp;
    int m_cnt, nv, ns;
    bit cap;
    always @(posedge CLK) begin
        if (RST) begin
            m_ack = 0; m_qv = 0; m_err = 0; m_q = '0; m_want_cw = 0; m_sexp = SP; m_cnt = 0;
            h1 = {}; h0 = {};
            for (int i = 0; i < SS; i++) begin h1.push_back({W{SP}}); h0.push_back({W{SP}}); end
        end else begin
            ms1 = h1.pop_front(); ms0 = h0.pop_front();
            h1.push_back(D_1); h0.push_back(D_0);
            nv = 0; ns = 0;
            for (int i = 0; i < W; i++) begin
                if (ms1[i] != ms0[i]) nv++;
                else if (ms1[i] == m_sexp) ns++;
                else m_err = 1;
            end
            cap = m_cnt >= SS && m_want_cw && nv == W && (!m_qv || Q_READY);
            if (cap) begin
                m_q = ms1; m_qv = 1; m_ack = 1; m_want_cw = 0;
`ifdef DR_RX_DECODER_ALT_SPACER_EN
                m_sexp = ~m_sexp;
`endif
            end else begin
                if (m_qv && Q_READY) m_qv = 0;
                if (m_cnt >= SS && !m_want_cw && ns == W) begin m_ack = 0; m_want_cw = 1; end
            end
            if (m_cnt < 1000) m_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic [W-1:0] d1, input logic [W-1:0] d0, input logic rdy);
        RST = rst; D_1 = d1; D_0 = d0; Q_READY = rdy;
        @(posedge CLK); #1;
        chk("model_ack", W'(ACK), W'(m_ack));
        chk("model_q", Q, m_q);
        chk("model_qv", W'(Q_VALID), W'(m_qv));
        chk("model_err", W'(ERR), W'(m_err));
    endtask

    task automatic hold(input int n, input logic [W-1:0] d1, input logic [W-1:0] d0, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, d1, d0, rdy);
    endtask

    task automatic outs(input string nm, input logic a, input logic [W-1:0] q, input logic v, input logic e);
        chk({nm, "_ack"}, W'(ACK), W'(a));
        chk({nm, "_q"}, Q, q);
        chk({nm, "_qv"}, W'(Q_VALID), W'(v));
        chk({nm, "_err"}, W'(ERR), W'(e));
    endtask

    typedef struct {
        logic rst; logic [W-1:0] d1, d0; logic rdy;
        logic ack; logic [W-1:0] q; logic qv, err;
    } vec_t;
    vec_t tv [16];
    logic [W-1:0] rd1, rd0, cw, mask, spc;
    int m;

    initial begin
        tv[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 4'hA, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 4'hA, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 4'hA, 4'h5, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'hA, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 4'h1, 4'h0, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0};
        tv[10] = '{1'b0, 4'h1, 4'h2, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0};
        tv[11] = '{1'b0, 4'h1, 4'h6, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0};
        tv[12] = '{1'b0, 4'h1, 4'hE, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0};
        tv[13] = '{1'b0, 4'h1, 4'hE, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0};
        tv[14] = '{1'b0, 4'h1, 4'hE, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0};
        tv[15] = '{1'b0, 4'h1, 4'hE, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0};
        for (int i = 0; i < 16; i++) begin
            step(tv[i].rst, tv[i].d1, tv[i].d0, tv[i].rdy);
            outs($sformatf("tv%0d", i), tv[i].ack, tv[i].q, tv[i].qv, tv[i].err);
        end
        // Full output blocks a complete codeword until the consumer is ready
        hold(3, 4'h0, 4'h0, 1'b0);
        outs("full_sp", 1'b0, 4'h1, 1'b0, 1'b0);
        hold(3, 4'h3, 4'hC, 1'b0);
        outs("full_cw1", 1'b1, 4'h3, 1'b1, 1'b0);
        hold(3, 4'h0, 4'h0, 1'b0);
        hold(5, 4'hC, 4'h3, 1'b0);
        outs("full_hold", 1'b0, 4'h3, 1'b1, 1'b0);
        step(1'b0, 4'hC, 4'h3, 1'b1);
        outs("full_release", 1'b1, 4'hC, 1'b1, 1'b0);
        // One-cycle illegal bit while waiting for a codeword
        hold(3, 4'h0, 4'h0, 1'b1);
        step(1'b0, 4'h4, 4'h4, 1'b1);
        step(1'b0, 4'h0, 4'h0, 1'b1);
        outs("ill_pre", 1'b0, 4'hC, 1'b0, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b1);
        outs("ill_set", 1'b0, 4'hC, 1'b0, 1'b1);
        hold(3, 4'h0, 4'h0, 1'b1);
        outs("ill_sticky", 1'b0, 4'hC, 1'b0, 1'b1);
        // Reset mid-handshake, then a codeword with no spacer in front
        hold(3, 4'h9, 4'h6, 1'b0);
        outs("rst_pre", 1'b1, 4'h9, 1'b1, 1'b1);
        step(1'b1, 4'h9, 4'h6, 1'b0);
        outs("rst_now", 1'b0, 4'h0, 1'b0, 1'b0);
        hold(6, 4'h9, 4'h6, 1'b1);
        outs("rst_nosp", 1'b0, 4'h0, 1'b0, 1'b0);
`ifdef DR_RX_DECODER_ALT_SPACER_EN
        hold(3, 4'h0, 4'h0, 1'b0);
        hold(3, 4'h6, 4'h9, 1'b0);
        outs("alt_cw", 1'b1, 4'h6, 1'b1, 1'b0);
        hold(3, 4'hF, 4'hF, 1'b0);
        outs("alt_sp1", 1'b0, 4'h6, 1'b1, 1'b0);
        hold(3, 4'h5, 4'hA, 1'b0);
        outs("alt_blocked", 1'b0, 4'h6, 1'b1, 1'b0);
        hold(3, 4'h0, 4'h0, 1'b0);
        outs("alt_sp0_err", 1'b0, 4'h6, 1'b1, 1'b1);
`endif
        step(1'b1, 4'h0, 4'h0, 1'b0);
        rd1 = '0; rd0 = '0;
        for (int n = 0; n < 500; n++) begin
            m = int'($urandom_range(0, 9));
            spc = {W{m_sexp}};
            if (m < 3) begin rd1 = spc; rd0 = spc; end
            else if (m < 6) begin end
            else if (m < 8) begin cw = W'($urandom); rd1 = cw; rd0 = ~cw; end
            else if (m == 8) begin
                mask = W'($urandom); cw = W'($urandom);
                rd1 = (cw & mask) | (spc & ~mask);
                rd0 = (~cw & mask) | (spc & ~mask);
            end else if ($urandom_range(0, 15) == 0) begin rd1 = spc ^ 4'h4; rd0 = spc ^ 4'h4; end
            step($urandom_range(0, 99) == 0, rd1, rd0, 1'($urandom_range(0, 1)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
